// File: rtl/bcd_conv_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_conv_arbiter_if : requester bus of the shared binary-to-BCD engine
// Rev 1.0
// ---------------------------------------------------------------------------
interface bcd_conv_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int N_REQ  = 4,
  parameter int DIGITS = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [2:0]             done_id;
  logic [DIGITS*4-1:0]    bcd_out;
  logic                   overload;

  modport master (
    output req, data_in,
    input  grant, busy, done, done_id, bcd_out, overload
  );

  modport slave (
    input  req, data_in,
    output grant, busy, done, done_id, bcd_out, overload
  );
endinterface
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_conv_arbiter : N_REQ requesters share one double-dabble BCD engine.
// Rev 1.0 -- define BCD_ARB_FIXED_PRIO_EN for fixed priority (default RR).
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
  parameter int WIDTH  = 8,
  parameter int N_REQ  = 4,
  parameter int DIGITS = 3
) (
  input  wire logic         clock,
  input  wire logic         reset,
  bcd_conv_arbiter_if.slave bus
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic             ovf;
  logic             ovf_next;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic [2:0]       winner;
  logic [2:0]       pick;
  logic             pick_valid;
  logic [N_REQ-1:0] excl;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic [2:0]       done_id;
  logic [BCD_W-1:0] bcd_out;
  logic             overload;
  logic             busy;

  // The requester just served stays masked for one IDLE cycle while its req falls.
  assign eligible  = bus.req & ~excl;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef BCD_ARB_FIXED_PRIO_EN
  always_comb begin
    pick       = 3'd0;
    pick_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        pick       = 3'(k);
        pick_valid = 1'b1;
      end
    end
  end
`else
  logic [2:0]       rr;
  logic [N_REQ-1:0] rot;
  logic [2:0]       offset;
  logic [3:0]       sum;

  // Rotate so bit 0 is the rr position; the lowest set bit is the winner.
  assign rot = N_REQ'({eligible, eligible} >> rr);

  always_comb begin
    offset     = 3'd0;
    pick_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset     = 3'(k);
        pick_valid = 1'b1;
      end
    end
    sum  = {1'b0, rr} + {1'b0, offset};
    pick = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr <= 3'd0;
    end else if (state == S_IDLE && pick_valid) begin
      rr <= (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
    end
  end
`endif

  always_comb begin
    operand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == 3'(k)) operand = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], shreg[WIDTH-1]};
    ovf_next = ovf | bcd_adj[BCD_W-1];
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pick_valid) state_next = S_SHIFT;
      S_SHIFT: if (last_iter)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Results are registered on the last iteration so done lands WIDTH cycles after grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg    <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      winner   <= 3'd0;
      excl     <= '0;
      grant    <= '0;
      done     <= 1'b0;
      done_id  <= 3'd0;
      bcd_out  <= '0;
      overload <= 1'b0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      excl  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            shreg  <= operand;
            bcd    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
            winner <= pick;
            grant  <= ONE << pick;
          end
        end
        S_SHIFT: begin
          shreg <= shreg << 1;
          bcd   <= bcd_next;
          ovf   <= ovf_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            done     <= 1'b1;
            done_id  <= winner;
            bcd_out  <= bcd_next;
            overload <= ovf_next;
          end
        end
        S_DONE:  excl <= ONE << winner;
        default: ;
      endcase
    end
  end

  assign bus.grant    = grant;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.done_id  = done_id;
  assign bus.bcd_out  = bcd_out;
  assign bus.overload = overload;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter : randomized bench with a behavioural arbiter/BCD model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

  localparam int WIDTH  = 8;
  localparam int N_REQ  = 4;
  localparam int DIGITS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcd_conv_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .DIGITS(DIGITS)) bus ();
  bcd_conv_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  bcd_conv_arbiter_if #(.WIDTH(8), .N_REQ(2), .DIGITS(2)) bus2 ();
  bcd_conv_arbiter #(.WIDTH(8), .N_REQ(2), .DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a countdown of busy cycles plus the last result.
  int                     m_cnt = 0, m_rr = 0, m_excl = -1, m_winner = 0, m_op = 0;
  logic [2:0]             m_id = '0;
  logic [DIGITS*4-1:0]    m_bcd = '0;
  logic                   m_ovf = 1'b0;
  logic [N_REQ-1:0]       exp_grant = '0;
  logic                   exp_busy = 1'b0, exp_done = 1'b0;
  logic [N_REQ-1:0]       prev_req = '0;
  logic [N_REQ*WIDTH-1:0] prev_data = '0;
  logic                   prev_reset = 1'b0;

  function automatic logic [DIGITS*4-1:0] ref_bcd(int v);
    logic [DIGITS*4-1:0] r = '0;
    int p = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(int v);
    int lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  function automatic int pick(logic [N_REQ-1:0] elig, int rr);
    int idx;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (rr + k) % N_REQ;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [N_REQ-1:0] elig;
    int w;
    exp_grant = '0;
    if (!prev_reset) begin
      m_cnt = 0; m_rr = 0; m_excl = -1; m_id = '0; m_bcd = '0; m_ovf = 1'b0;
    end else if (m_cnt == 0) begin
      elig = prev_req;
      if (m_excl >= 0) elig[m_excl] = 1'b0;
      m_excl = -1;
      w = pick(elig, m_rr);
      if (w >= 0) begin
        exp_grant[w] = 1'b1;
        m_winner = w;
        m_op     = int'(prev_data[w*WIDTH +: WIDTH]);
        m_cnt    = WIDTH + 1;
`ifdef BCD_ARB_FIXED_PRIO_EN
        m_rr = 0;
`else
        m_rr = (w + 1) % N_REQ;
`endif
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_id  = 3'(m_winner);
        m_bcd = ref_bcd(m_op);
        m_ovf = ref_ovf(m_op);
      end
      if (m_cnt == 0) m_excl = m_winner;
    end
    exp_busy = (m_cnt != 0);
    exp_done = (m_cnt == 1);
  endtask

  task automatic cycle();
    prev_req   = bus.req;
    prev_data  = bus.data_in;
    prev_reset = reset;
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = '0;  bus.data_in = '0;
    bus2.req = '0; bus2.data_in = '0;
    repeat (3) cycle();
    n_checks++;
    if ({bus.grant, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.overload} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b busy=%b done=%b id=%0d bcd=%h ovf=%b, expected all 0",
               bus.grant, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.overload);
    end
    n_checks++;
    if ({bus2.grant, bus2.busy, bus2.done, bus2.done_id, bus2.bcd_out, bus2.overload} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: got grant=%b busy=%b done=%b bcd=%h ovf=%b, expected all 0",
               bus2.grant, bus2.busy, bus2.done, bus2.bcd_out, bus2.overload);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int g_cyc = -1, d_cyc = -1, busy_n = 0;
    logic [N_REQ-1:0] g_seen = '0;
    bus.req = 4'b0001;
    bus.data_in = '0;
    bus.data_in[7:0] = 8'd255;
    for (int c = 0; c < 20; c++) begin
      cycle();
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL single_ctrl: grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      if (bus.grant != '0 && g_cyc < 0) begin g_cyc = c; g_seen = bus.grant; end
      if (bus.busy) busy_n++;
      if (bus.done && d_cyc < 0) begin
        d_cyc = c;
        bus.req = '0;
        n_checks++;
        if ({bus.done_id, bus.bcd_out, bus.overload} !== {3'd0, 12'h255, 1'b0}) begin
          n_fail++;
          $display("FAIL single_result: id/bcd/ovf=%0d/%h/%b expected 0/255/0",
                   bus.done_id, bus.bcd_out, bus.overload);
        end
      end
    end
    n_checks++;
    if (g_seen !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: got %b expected 0001", g_seen);
    end
    n_checks++;
    if (d_cyc - g_cyc != 8) begin
      n_fail++; $display("FAIL single_latency: got %0d expected 8", d_cyc - g_cyc);
    end
    n_checks++;
    if (busy_n != 9) begin
      n_fail++; $display("FAIL single_busy_cycles: got %0d expected 9", busy_n);
    end
  endtask

  task automatic test_two_req();
    int dcnt[N_REQ];
    int n_done = 0, n_grant = 0;
    logic [2:0]  ids[2];
    logic [11:0] bcds[2];
    ids = '{3'd7, 3'd7};
    bcds = '{12'hfff, 12'hfff};
    foreach (dcnt[i]) dcnt[i] = -1;
    reset = 1'b0; cycle(); cycle(); reset = 1'b1;
    bus.data_in = '0;
    bus.data_in[7:0]   = 8'd42;
    bus.data_in[23:16] = 8'd7;
    bus.req = 4'b0101;
    for (int c = 0; c < 40; c++) begin
      cycle();
      // Requesters release req two cycles after their done, covering the masked IDLE cycle.
      for (int i = 0; i < N_REQ; i++) begin
        if (dcnt[i] > 0) begin
          dcnt[i]--;
          if (dcnt[i] == 0) bus.req[i] = 1'b0;
        end
      end
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL two_ctrl: grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      n_checks++;
      if ({bus.done_id, bus.bcd_out, bus.overload} !== {m_id, m_bcd, m_ovf}) begin
        n_fail++;
        $display("FAIL two_result: id/bcd/ovf=%0d/%h/%b expected %0d/%h/%b",
                 bus.done_id, bus.bcd_out, bus.overload, m_id, m_bcd, m_ovf);
      end
      if (bus.grant != '0) n_grant++;
      if (bus.done) begin
        if (n_done < 2) begin ids[n_done] = bus.done_id; bcds[n_done] = bus.bcd_out; end
        n_done++;
        dcnt[bus.done_id] = 2;
      end
    end
    n_checks++;
    if ({ids[0], bcds[0], ids[1], bcds[1]} !== {3'd0, 12'h042, 3'd2, 12'h007}) begin
      n_fail++;
      $display("FAIL two_order: got id%0d=%h id%0d=%h expected id0=042 id2=007",
               ids[0], bcds[0], ids[1], bcds[1]);
    end
    n_checks++;
    if (n_grant != 2) begin
      n_fail++; $display("FAIL two_no_reserve: got %0d grants expected 2", n_grant);
    end
  endtask

  task automatic test_digits2();
    logic [7:0] ops[3];
    logic [7:0] exp_b[3];
    logic       exp_o[3];
    logic       seen;
    ops   = '{8'd99, 8'd100, 8'd0};
    exp_b = '{8'h99, 8'h00, 8'h00};
    exp_o = '{1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      bus2.data_in = '0;
      bus2.data_in[7:0] = ops[t];
      bus2.req = 2'b01;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        cycle();
        if (bus2.done) seen = 1'b1;
      end
      bus2.req = '0;
      n_checks++;
      if (!seen || {bus2.bcd_out, bus2.overload} !== {exp_b[t], exp_o[t]}) begin
        n_fail++;
        $display("FAIL digits2_op%0d: done=%b bcd=%h ovf=%b expected done=1 bcd=%h ovf=%b",
                 ops[t], seen, bus2.bcd_out, bus2.overload, exp_b[t], exp_o[t]);
      end
      repeat (3) cycle();
    end
  endtask

  task automatic test_all_req();
    int order[5];
    int exp_order[5];
    int n_g = 0, gi;
`ifdef BCD_ARB_FIXED_PRIO_EN
    exp_order = '{0, 3, 0, 3, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    order = '{-1, -1, -1, -1, -1};
    reset = 1'b0; cycle(); cycle(); reset = 1'b1;
`ifdef BCD_ARB_FIXED_PRIO_EN
    bus.req = 4'b1001;
`else
    bus.req = 4'b1111;
`endif
    for (int c = 0; c < 80 && n_g < 5; c++) begin
      for (int i = 0; i < N_REQ; i++) bus.data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom());
      cycle();
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL all_ctrl: grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      n_checks++;
      if ({bus.done_id, bus.bcd_out, bus.overload} !== {m_id, m_bcd, m_ovf}) begin
        n_fail++;
        $display("FAIL all_result: id/bcd/ovf=%0d/%h/%b expected %0d/%h/%b",
                 bus.done_id, bus.bcd_out, bus.overload, m_id, m_bcd, m_ovf);
      end
      gi = -1;
      for (int k = 0; k < N_REQ; k++) if (bus.grant[k]) gi = k;
      if (gi >= 0) begin order[n_g] = gi; n_g++; end
    end
    n_checks++;
    if (order != exp_order) begin
      n_fail++;
      $display("FAIL all_order: got %0d,%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d,%0d",
               order[0], order[1], order[2], order[3], order[4],
               exp_order[0], exp_order[1], exp_order[2], exp_order[3], exp_order[4]);
    end
    bus.req = '0;
    repeat (12) cycle();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    bus.data_in = '0;
    bus.data_in[7:0] = 8'd200;
    bus.req = 4'b0001;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (bus.grant != '0) seen = 1'b1;
    end
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    n_checks++;
    if ({bus.grant, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.overload} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: grant=%b busy=%b done=%b id=%0d bcd=%h ovf=%b expected all 0",
               bus.grant, bus.busy, bus.done, bus.done_id, bus.bcd_out, bus.overload);
    end
    reset = 1'b1;
    bus.data_in[7:0] = 8'd128;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL midreset_ctrl: grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      if (bus.done) seen = 1'b1;
    end
    bus.req = '0;
    n_checks++;
    if (!seen || {bus.done_id, bus.bcd_out, bus.overload} !== {3'd0, 12'h128, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_result: done=%b id/bcd/ovf=%0d/%h/%b expected 1 0/128/0",
               seen, bus.done_id, bus.bcd_out, bus.overload);
    end
    repeat (3) cycle();
  endtask

  task automatic test_capture();
    logic seen = 1'b0;
    bus.data_in = '0;
    bus.data_in[15:8] = 8'd63;
    bus.req = 4'b0010;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (bus.grant != '0) seen = 1'b1;
    end
    bus.data_in[15:8] = 8'd200;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      cycle();
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL capture_ctrl: grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      if (bus.done) seen = 1'b1;
    end
    bus.req = '0;
    n_checks++;
    if (!seen || {bus.done_id, bus.bcd_out, bus.overload} !== {3'd1, 12'h063, 1'b0}) begin
      n_fail++;
      $display("FAIL capture_result: done=%b id/bcd/ovf=%0d/%h/%b expected 1 1/063/0",
               seen, bus.done_id, bus.bcd_out, bus.overload);
    end
    repeat (3) cycle();
  endtask

  task automatic test_random();
    int dcnt[N_REQ];
    int n_done = 0;
    foreach (dcnt[i]) dcnt[i] = -1;
    bus.req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        bus.data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom());
        if (dcnt[i] == 0) begin
          bus.req[i] = 1'b0;
          dcnt[i] = -1;
        end else if (dcnt[i] > 0) begin
          dcnt[i]--;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      cycle();
      n_checks++;
      if ({bus.grant, bus.busy, bus.done} !== {exp_grant, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL random_ctrl: cycle %0d grant/busy/done=%b/%b/%b expected %b/%b/%b",
                 c, bus.grant, bus.busy, bus.done, exp_grant, exp_busy, exp_done);
      end
      n_checks++;
      if ({bus.done_id, bus.bcd_out, bus.overload} !== {m_id, m_bcd, m_ovf}) begin
        n_fail++;
        $display("FAIL random_result: cycle %0d id/bcd/ovf=%0d/%h/%b expected %0d/%h/%b",
                 c, bus.done_id, bus.bcd_out, bus.overload, m_id, m_bcd, m_ovf);
      end
      if (bus.done && bus.done_id < 3'(N_REQ)) begin
        n_done++;
        dcnt[bus.done_id] = int'($urandom_range(0, 2));
      end
    end
    n_checks++;
    if (n_done < 10) begin
      n_fail++; $display("FAIL random_throughput: got %0d results expected at least 10", n_done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two_req();
    test_digits2();
    test_all_req();
    test_reset_mid();
    test_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
